// File: rtl/wb_merge.sv
// Register-file writeback merge of the main pipeline and a divider, with a 2-entry divider result FIFO.
// Optional macro WB_MERGE_FWD_EN adds a combinational forwarding lookup into the buffered results.
module wb_merge (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_en,
  input  logic [4:0]  pipe_addr,
  input  logic [31:0] pipe_result,
  input  logic        div_en_in,
  input  logic [4:0]  div_addr_in,
  input  logic [31:0] div_result,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        buf_full,
  output logic [1:0]  buf_count
`ifdef WB_MERGE_FWD_EN
  ,
  input  logic [4:0]  fwd_addr,
  output logic        fwd_hit,
  output logic [31:0] fwd_data
`endif
);

  logic [4:0]  addr_q [2];
  logic [4:0]  addr_d [2];
  logic [31:0] data_q [2];
  logic [31:0] data_d [2];
  logic [1:0]  vld_q, vld_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d, cnt_mid;
  logic        ovf_q, ovf_d;
  logic        wb_en_q, wb_en_d;
  logic [4:0]  wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;

  logic pipe_v, div_v, deq, direct, div_shadow, want_enq, enq, ovf_set, wr_idx;

  // Writes to r0 are discarded outright, so they never claim the write port.
  assign pipe_v     = pipe_en && (pipe_addr != 5'd0);
  assign div_v      = div_en_in && (div_addr_in != 5'd0);
  assign deq        = !pipe_v && (count_q != 2'd0);
  assign direct     = !pipe_v && (count_q == 2'd0) && div_v;
  assign div_shadow = pipe_v && (div_addr_in == pipe_addr);
  assign cnt_mid    = count_q - {1'b0, deq};
  assign want_enq   = div_v && !direct && !div_shadow;
  assign enq        = want_enq && (cnt_mid != 2'd2);
  assign ovf_set    = want_enq && (cnt_mid == 2'd2);
  assign rd_ptr_d   = rd_ptr_q ^ deq;
  assign wr_idx     = rd_ptr_d ^ cnt_mid[0];
  assign count_d    = cnt_mid + {1'b0, enq};
  assign ovf_d      = ovf_q || ovf_set;

  always_comb begin
    vld_d     = vld_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wb_en_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    // The pipeline result is younger than anything buffered for the same register.
    for (int i = 0; i < 2; i++) begin
      if (pipe_v && (addr_q[i] == pipe_addr)) vld_d[i] = 1'b0;
    end
    if (pipe_v) begin
      wb_en_d   = 1'b1;
      wb_addr_d = pipe_addr;
      wb_data_d = pipe_result;
    end else if (deq) begin
      vld_d[rd_ptr_q] = 1'b0;
      if (vld_q[rd_ptr_q]) begin
        wb_en_d   = 1'b1;
        wb_addr_d = addr_q[rd_ptr_q];
        wb_data_d = data_q[rd_ptr_q];
      end
    end else if (direct) begin
      wb_en_d   = 1'b1;
      wb_addr_d = div_addr_in;
      wb_data_d = div_result;
    end
    if (enq) begin
      vld_d[wr_idx]  = 1'b1;
      addr_d[wr_idx] = div_addr_in;
      data_d[wr_idx] = div_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= 2'b00;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      ovf_q     <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= 5'd0;
      wb_data_q <= 32'd0;
    end else begin
      assert (!ovf_set);
      vld_q     <= vld_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign wb_en     = wb_en_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign buf_count = count_q;
  assign buf_full  = (count_q == 2'd2);

`ifdef WB_MERGE_FWD_EN
  logic yng, old;
  assign yng = rd_ptr_q ^ 1'b1;
  assign old = rd_ptr_q;

  // Valid bits are cleared on dequeue, so a set bit always marks an occupied slot.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = 32'd0;
    if (fwd_addr != 5'd0) begin
      if (vld_q[yng] && (addr_q[yng] == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[yng];
      end else if (vld_q[old] && (addr_q[old] == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[old];
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_merge.sv
// Randomized and directed bench for wb_merge against a queue-based writeback model.
module tb_wb_merge;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_en;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_result;
  logic        div_en_in;
  logic [4:0]  div_addr_in;
  logic [31:0] div_result;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        buf_full;
  logic [1:0]  buf_count;
`ifdef WB_MERGE_FWD_EN
  logic [4:0]  fwd_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
`endif

  always #5 clk = ~clk;

  wb_merge dut (
    .clk(clk), .rst(rst),
    .pipe_en(pipe_en), .pipe_addr(pipe_addr), .pipe_result(pipe_result),
    .div_en_in(div_en_in), .div_addr_in(div_addr_in), .div_result(div_result),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .buf_full(buf_full), .buf_count(buf_count)
`ifdef WB_MERGE_FWD_EN
    , .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    bit          v;
  } ent_t;

  ent_t        mq[$];
  logic        e_en;
  logic [4:0]  e_addr;
  logic [31:0] e_data;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, advance the model by the writeback rules, compare.
  task automatic cyc(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                     input logic dv, input logic [4:0] da, input logic [31:0] dd);
    ent_t h;
    bit pe, de, hit;
    logic [31:0] fd;
    pipe_en = pv; pipe_addr = pa; pipe_result = pd;
    div_en_in = dv; div_addr_in = da; div_result = dd;
`ifdef WB_MERGE_FWD_EN
    fwd_addr = 5'($urandom_range(0, 7));
`endif
    @(posedge clk);
    pe = pv && (pa != 5'd0);
    de = dv && (da != 5'd0);
    e_en = 1'b0;
    if (rst) begin
      mq.delete();
      e_addr = 5'd0;
      e_data = 32'd0;
    end else if (pe) begin
      e_en = 1'b1; e_addr = pa; e_data = pd;
      foreach (mq[i]) if (mq[i].a == pa) mq[i].v = 1'b0;
      if (de && da != pa) mq.push_back('{da, dd, 1'b1});
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      if (h.v) begin
        e_en = 1'b1; e_addr = h.a; e_data = h.d;
      end
      if (de) mq.push_back('{da, dd, 1'b1});
    end else if (de) begin
      e_en = 1'b1; e_addr = da; e_data = dd;
    end
    #1;
    chk("wb_en", 32'(wb_en), 32'(e_en));
    chk("wb_addr", 32'(wb_addr), 32'(e_addr));
    chk("wb_data", wb_data, e_data);
    chk("buf_count", 32'(buf_count), 32'(mq.size()));
    chk("buf_full", 32'(buf_full), 32'(mq.size() == 2));
`ifdef WB_MERGE_FWD_EN
    hit = 1'b0; fd = 32'd0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (!hit && fwd_addr != 5'd0 && mq[i].v && mq[i].a == fwd_addr) begin
        hit = 1'b1; fd = mq[i].d;
      end
    end
    chk("fwd_hit", 32'(fwd_hit), 32'(hit));
    if (hit) chk("fwd_data", fwd_data, fd);
`endif
  endtask

  task automatic idle();
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    logic pv, dv;
    logic [4:0] pa, da;
    rst = 1'b1;
    idle();
    idle();
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_count", 32'(buf_count), 32'd0);
    rst = 1'b0;

    cyc(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'd0);
    chk("single_en", 32'(wb_en), 32'd1);
    chk("single_addr", 32'(wb_addr), 32'd3);
    chk("single_data", wb_data, 32'h11);

    cyc(1'b1, 5'd4, 32'hA, 1'b1, 5'd5, 32'hB);
    chk("both_data", wb_data, 32'hA);
    chk("both_count", 32'(buf_count), 32'd1);
    idle();
    chk("drain_addr", 32'(wb_addr), 32'd5);
    chk("drain_data", wb_data, 32'hB);
    chk("drain_count", 32'(buf_count), 32'd0);

    cyc(1'b1, 5'd1, 32'h21, 1'b1, 5'd6, 32'hD6);
    cyc(1'b1, 5'd6, 32'h7, 1'b0, 5'd0, 32'd0);
    chk("kill_data", wb_data, 32'h7);
    idle();
    chk("kill_no_wr", 32'(wb_en), 32'd0);
    idle();
    chk("kill_empty", 32'(buf_count), 32'd0);

    cyc(1'b1, 5'd1, 32'h31, 1'b1, 5'd10, 32'hA10);
    cyc(1'b1, 5'd2, 32'h32, 1'b0, 5'd0, 32'd0);
    cyc(1'b1, 5'd3, 32'h33, 1'b1, 5'd11, 32'hA11);
    chk("full_flag", 32'(buf_full), 32'd1);
    idle();
    chk("order0", 32'(wb_addr), 32'd10);
    idle();
    chk("order1", 32'(wb_addr), 32'd11);

    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    chk("r0_en", 32'(wb_en), 32'd0);
    chk("r0_count", 32'(buf_count), 32'd0);

    cyc(1'b1, 5'd1, 32'h41, 1'b1, 5'd12, 32'hC12);
    cyc(1'b1, 5'd2, 32'h42, 1'b1, 5'd13, 32'hC13);
    chk("pre_rst_full", 32'(buf_count), 32'd2);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    chk("post_rst_count", 32'(buf_count), 32'd0);
    chk("post_rst_en", 32'(wb_en), 32'd0);
    for (int k = 0; k < 3; k++) idle();

    for (int n = 0; n < 2000; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      pv = 1'($urandom_range(0, 1));
      pa = 5'($urandom_range(0, 7));
      dv = ($urandom_range(0, 2) == 0);
      da = 5'($urandom_range(0, 7));
      if (pv && pa != 5'd0 && mq.size() == 2) dv = 1'b0;
      cyc(pv, pa, $urandom, dv, da, $urandom);
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_merge.md
WB_MERGE -- requirements
Module: wb_merge

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous reset, active-high.
REQ-003 SHALL have port: pipe_en  input  1  main-pipeline writeback valid.
REQ-004 SHALL have port: pipe_addr  input  5  main-pipeline destination register.
REQ-005 SHALL have port: pipe_result  input  32  main-pipeline writeback data.
REQ-006 SHALL have port: div_en_in  input  1  divider result valid, single-cycle pulse.
REQ-007 SHALL have port: div_addr_in  input  5  divider destination register.
REQ-008 SHALL have port: div_result  input  32  divider quotient/remainder.
REQ-009 SHALL have port: wb_en  output  1  register-file write enable.
REQ-010 SHALL have port: wb_addr  output  5  register-file write address.
REQ-011 SHALL have port: wb_data  output  32  register-file write data.
REQ-012 SHALL have port: buf_full  output  1  two divider results pending; divider issue held.
REQ-013 SHALL have port: buf_count  output  2  number of valid buffered divider results (0..2).

Function
REQ-014 SHALL register wb_en/wb_addr/wb_data; latency is exactly 1 cycle from the accepted source to the output.
REQ-015 SHALL hold a 2-entry FIFO of {addr, data, valid} for divider results awaiting the write port.
REQ-016 SHALL give priority per cycle: pipe_en, then FIFO head, then direct div_en_in.
REQ-017 SHALL, on pipe_en with div_en_in, write pipe and enqueue the divider result.
REQ-018 SHALL, with no pipe_en and FIFO non-empty, write the head and dequeue it; a simultaneous div_en_in enqueues, preserving order.
REQ-019 SHALL, with no pipe_en, FIFO empty and div_en_in, write the divider result directly without enqueueing.
REQ-020 SHALL discard any write with address 0: no wb_en, no enqueue.
REQ-021 SHALL, on pipe_en, invalidate every buffered entry whose addr equals pipe_addr; invalidated entries are dequeued without asserting wb_en.
REQ-022 SHALL, on pipe_en with div_en_in and equal addresses, drop the divider result (pipe is younger).
REQ-023 SHALL drive wb_en=0 in any cycle where no source is written; wb_addr/wb_data hold their previous values.
REQ-024 SHALL assert buf_full combinationally when buf_count==2; a div_en_in arriving while full and not drained in that cycle is dropped and sets sticky internal flag ovf (simulation assertion).
REQ-025 SHALL drive buf_count from registered occupancy (invalid-but-not-dequeued entries counted).

Reset
REQ-026 SHALL, on rst, clear wb_en, wb_addr, wb_data, all FIFO valid bits, pointers, buf_count and ovf to 0 in the same cycle.
REQ-027 SHALL discard buffered entries and any input arriving with rst high; first possible wb_en is the cycle after rst falls plus one.

Configuration
REQ-028 SHALL, with WB_MERGE_FWD_EN defined, add ports fwd_addr input 5, fwd_hit output 1, fwd_data output 32: combinational lookup of youngest valid buffered entry with addr==fwd_addr (fwd_addr 0 never hits).
REQ-029 SHALL, without WB_MERGE_FWD_EN, omit those ports and lookup logic; all other behaviour identical.

Verification
REQ-030 SHALL check: pipe_en=1 addr 3 data 0x11 alone -> next cycle wb_en=1, wb_addr=3, wb_data=0x11, buf_count=0.
REQ-031 SHALL check: pipe_en addr 4 data 0xA with div_en_in addr 5 data 0xB -> cycle+1 writes r4=0xA, buf_count=1; cycle+2 (idle) writes r5=0xB, buf_count=0.
REQ-032 SHALL check: div addr 6 buffered, then pipe_en addr 6 data 0x7 -> r6=0x7 written, buffered entry dropped, r6 never rewritten with divider data.
REQ-033 SHALL check: three back-to-back pipe_en cycles with div_en_in on cycles 1 and 3 -> buf_full=1 after cycle 3, drains in order over next two idle cycles.
REQ-034 SHALL check: div_en_in addr 0 data 0xFFFFFFFF -> wb_en stays 0, buf_count stays 0.
REQ-035 SHALL check: rst asserted with buf_count=2 -> next cycle buf_count=0, wb_en=0, no buffered write ever appears; with WB_MERGE_FWD_EN, fwd_hit=0.
